// File: rtl/unsigned_mul_8x8_ha_array_reducer.sv
// rtl/unsigned_mul_8x8_ha_array_reducer.sv - two-stage exact weighted sum of four HA row-pair arrays
// Stage 1 folds array pairs, stage 2 forms the full sum; valid/ready with full backpressure.
module unsigned_mul_8x8_ha_array_reducer #(
  parameter int OUT_W            = 16,
  parameter int REG_OUT_ON_STALL = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       ha_array_0_b,
  input  logic [6:0]       ha_array_1_b,
  input  logic [6:0]       ha_array_2_b,
  input  logic [6:0]       ha_array_3_b,
  input  logic [8:0]       ha_array_0_t,
  input  logic [8:0]       ha_array_1_t,
  input  logic [8:0]       ha_array_2_t,
  input  logic [8:0]       ha_array_3_t,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] product,
  output logic             ovf
);

  localparam int A_W = 10;
  // A + 4*A peaks at 5095, so the pair sums need 13 bits to stay exact.
  localparam int P_W = 13;
  localparam int S_W = OUT_W + 1;
  localparam logic HOLD_ON_STALL = (REG_OUT_ON_STALL != 0);

  function automatic logic [A_W-1:0] array_value(input logic [6:0] b, input logic [8:0] t);
    return A_W'(t) + A_W'({b, 2'b00});
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic             out_valid_q, out_valid_d;
  logic [P_W-1:0]   p01_q, p01_d;
  logic [P_W-1:0]   p23_q, p23_d;
  logic [OUT_W-1:0] product_q;
  logic             ovf_q;
  logic [S_W-1:0]   sum_d;
  logic             s2_adv;
  logic             in_accept;
  logic             s2_load;

  always_comb begin
    s2_adv      = !out_valid_q || out_ready || !HOLD_ON_STALL;
    in_ready    = !rst && (!s1_valid_q || s2_adv);
    in_accept   = in_valid && in_ready;
    s2_load     = s1_valid_q && s2_adv;
    s1_valid_d  = in_accept || (s1_valid_q && !s2_adv);
    out_valid_d = s2_load || (out_valid_q && !out_ready);
    p01_d = P_W'(array_value(ha_array_0_b, ha_array_0_t))
          + (P_W'(array_value(ha_array_1_b, ha_array_1_t)) << 2);
    p23_d = P_W'(array_value(ha_array_2_b, ha_array_2_t))
          + (P_W'(array_value(ha_array_3_b, ha_array_3_t)) << 2);
    sum_d = S_W'(p01_q) + (S_W'(p23_q) << 4);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      out_valid_q <= 1'b0;
      product_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      out_valid_q <= out_valid_d;
      if (in_accept) begin
        p01_q <= p01_d;
        p23_q <= p23_d;
      end
      if (s2_load) begin
        product_q <= sum_d[OUT_W-1:0];
        ovf_q     <= sum_d[OUT_W];
      end
    end
  end

  assign out_valid = out_valid_q;
  assign product   = product_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_array_reducer.sv
// tb/tb_unsigned_mul_8x8_ha_array_reducer.sv - scoreboard bench for the HA array reducer
module tb_unsigned_mul_8x8_ha_array_reducer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] product;
  logic        ovf;
  logic [6:0]  bb[4];
  logic [8:0]  tt[4];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int or_mode = 0;

  typedef struct {
    logic [15:0] prod;
    logic        ovf;
    int          acc_cyc;
    bit          strict;
  } exp_t;
  exp_t q[$];

  bit          prev_stall = 1'b0;
  logic [15:0] prev_prod;
  logic        prev_ovf;

  unsigned_mul_8x8_ha_array_reducer #(.OUT_W(16), .REG_OUT_ON_STALL(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ha_array_0_b(bb[0]), .ha_array_1_b(bb[1]), .ha_array_2_b(bb[2]), .ha_array_3_b(bb[3]),
    .ha_array_0_t(tt[0]), .ha_array_1_t(tt[1]), .ha_array_2_t(tt[2]), .ha_array_3_t(tt[3]),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .ovf(ovf)
  );

  always #5 clk = ~clk;

  // Each set bit contributes its positional weight, shifted by two per array.
  function automatic int unsigned model_sum();
    int unsigned s = 0;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 9; i++) if (tt[k][i]) s += 32'd1 << (i + 2 * k);
      for (int j = 0; j < 7; j++) if (bb[k][j]) s += 32'd1 << (j + 2 + 2 * k);
    end
    return s;
  endfunction

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin
    logic exp_ir;
    int unsigned s;
    exp_t e;
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      exp_ir = !(q.size() == 2 && out_valid && !out_ready);
      total++;
      if (in_ready !== exp_ir) begin
        bad++;
        $display("FAIL in_ready: got %b want %b (cycle %0d)", in_ready, exp_ir, cyc);
      end
      if (prev_stall) begin
        total++;
        if (out_valid !== 1'b1 || product !== prev_prod || ovf !== prev_ovf) begin
          bad++;
          $display("FAIL stall_hold: got v=%b p=%0d o=%b want v=1 p=%0d o=%b",
                   out_valid, product, ovf, prev_prod, prev_ovf);
        end
      end
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_output: got p=%0d o=%b want no output", product, ovf);
        end else begin
          e = q.pop_front();
          if (product !== e.prod || ovf !== e.ovf) begin
            bad++;
            $display("FAIL result: got p=%0d o=%b want p=%0d o=%b", product, ovf, e.prod, e.ovf);
          end
          if (e.strict) begin
            total++;
            if (cyc != e.acc_cyc + 2) begin
              bad++;
              $display("FAIL latency: got %0d want 2", cyc - e.acc_cyc);
            end
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_prod  = product;
      prev_ovf   = ovf;
      if (in_valid && in_ready) begin
        s = model_sum();
        e.prod    = 16'(s % 65536);
        e.ovf     = (s >= 65536);
        e.acc_cyc = cyc;
        e.strict  = (or_mode == 0);
        q.push_back(e);
      end
    end
  end

  task automatic clear_data();
    for (int k = 0; k < 4; k++) begin
      bb[k] = '0;
      tt[k] = '0;
    end
  endtask

  task automatic rand_data();
    for (int k = 0; k < 4; k++) begin
      bb[k] = 7'($urandom);
      tt[k] = 9'($urandom);
    end
  endtask

  task automatic send();
    int n = 0;
    bit acc = 1'b0;
    in_valid = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got no accept want accept within 200 cycles");
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
  endtask

  task automatic set_mode(input int m);
    or_mode = m;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    clear_data();
    rst = 1'b1;
    in_valid = 1'b1;
    rand_data();
    @(posedge clk);
    repeat (3) begin
      #1;
      rand_data();
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || product !== 16'd0 || ovf !== 1'b0 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL reset_state: got v=%b p=%0d o=%b ir=%b want 0 0 0 0",
                 out_valid, product, ovf, in_ready);
      end
      @(posedge clk);
    end
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    clear_data(); tt[0][0] = 1'b1; send();
    clear_data(); tt[3][8] = 1'b1; send();
    clear_data(); bb[2][6] = 1'b1; send();
    for (int k = 0; k < 4; k++) begin
      bb[k] = '1;
      tt[k] = '1;
    end
    send();
    clear_data(); send();
    drain();

    for (int i = 0; i < 100; i++) begin
      rand_data();
      send();
    end
    drain();

    set_mode(1);
    for (int i = 0; i < 1000; i++) begin
      rand_data();
      send();
    end
    drain();

    set_mode(2);
    rand_data(); send();
    rand_data(); send();
    in_valid = 1'b0;
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL both_full_in_ready: got %b want 0", in_ready);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
    total++;
    if (out_valid !== 1'b0 || product !== 16'd0) begin
      bad++;
      $display("FAIL midflight_reset: got v=%b p=%0d want v=0 p=0", out_valid, product);
    end
    rst = 1'b0;
    set_mode(0);
    rand_data(); send();
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
